inst_prefetch_queue: RTL

//  Fetch-side buffer that sits between the instruction memory and the IF/ID register.

---
 rtl/inst_prefetch_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch over req/ack + rvalid, in-order queue of {pc, instr}
// feeding IF/ID, with redirect flush that discards responses still in flight from the old stream.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_instr_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic        req, ack_fire, push, pop;
  logic [CW:0] inflight;
  logic [31:0] rsp_pc;

  assign inflight = {1'b0, count_q} + {1'b0, out_q};

  always_comb begin
    req = 1'b0;
    case (state_q)
      FETCH:   req = pend_q || (inflight < DEPTH_W);
      FLUSH:   req = pend_q;
      default: req = 1'b0;
    endcase
  end

  // An unacked request keeps its own address even after fetch_pc has been redirected.
  assign imem_req_o  = req;
  assign imem_addr_o = pend_q ? pend_addr_q : fetch_pc_q;
  assign ack_fire    = req && imem_ack_i;
  assign pop         = (count_q != '0) && !stall_i;
  assign push        = (state_q == FETCH) && imem_rvalid_i && !redirect_i;
  // Live requests are contiguous, so the oldest one sits out_q words behind fetch_pc.
  assign rsp_pc      = fetch_pc_q - 32'({out_q, 2'b00});

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = req && !imem_ack_i;
    pend_addr_d = imem_addr_o;
    count_d     = count_q;
    out_d       = out_q;
    drop_d      = drop_q;
    head_d      = head_q;
    tail_d      = tail_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_i) fetch_pc_d = redirect_pc_i;
      end
      FETCH: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
          count_d    = '0;
          out_d      = '0;
          head_d     = '0;
          tail_d     = '0;
          drop_d     = out_q - CW'(imem_rvalid_i) + CW'(req);
          state_d    = (drop_d == '0) ? FETCH : FLUSH;
        end else begin
          if (ack_fire) fetch_pc_d = fetch_pc_q + 32'd4;
          out_d   = out_q + CW'(ack_fire) - CW'(imem_rvalid_i);
          count_d = count_q + CW'(push) - CW'(pop);
          if (push) tail_d = tail_q + AW'(1);
          if (pop)  head_d = head_q + AW'(1);
        end
      end
      FLUSH: begin
        if (redirect_i) fetch_pc_d = redirect_pc_i;
        if (imem_rvalid_i) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= RESET_PC;
      count_q     <= '0;
      out_q       <= '0;
      drop_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[tail_q]    <= rsp_pc;
      instr_mem_q[tail_q] <= imem_rdata_i;
    end
  end

  assign if_valid_o = (count_q != '0);
  assign if_pc_o    = if_valid_o ? pc_mem_q[head_q] : 32'h0;
  assign if_pc4_o   = if_pc_o + 32'd4;
  assign if_instr_o = if_valid_o ? instr_mem_q[head_q] : 32'h0;

  // Counter underflow or a response into a full queue means the memory broke the protocol.
  always @(posedge clk_i) begin
    if (!reset_i && imem_rvalid_i) begin
      assert (state_q != IDLE);
      if (state_q == FETCH) assert (out_q != '0 && count_q != DEPTH_C);
      if (state_q == FLUSH) assert (drop_q != '0);
    end
  end

endmodule
